tcs34725_color_sampler: RTL and testbench

Sequencer directly upstream of i2c_master_read2bytes: drives its start/dev_addr/reg_addr, waits for done, and collects the four TCS34725 16-bit channels (clear, red, green, blue) in one sample. Publishes all four channels atomically with a one-cycle valid strobe, plus a dominant-colour code for the counting logic downstream. Sampling runs on a one-shot trigger or on a free-running period timer. A watchdog aborts a stalled I2C transaction.

---
 rtl/tcs34725_color_sampler.sv | 140 ++++++++++++++
 tb/tb_tcs34725_color_sampler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcs34725_color_sampler.sv
// Sequencer that reads the four TCS34725 colour channels through i2c_master_read2bytes,
// publishes them together with a one-cycle strobe and classifies the dominant colour.
module tcs34725_color_sampler #(
   parameter logic [6:0]  DEV_ADDR       = 7'h29,
   parameter logic [7:0]  CMD_PREFIX     = 8'hA0,
   parameter bit          SWAP_BYTES     = 1'b1,
   parameter int unsigned SAMPLE_PERIOD  = 5_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
   parameter logic [15:0] CLEAR_MIN      = 16'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic        auto_en,
   output logic        m_start,
   output logic [6:0]  m_dev_addr,
   output logic [7:0]  m_reg_addr,
   input  logic [15:0] m_data,
   input  logic        m_busy,
   input  logic        m_done,
   output logic [15:0] clear_o,
   output logic [15:0] red_o,
   output logic [15:0] green_o,
   output logic [15:0] blue_o,
   output logic        sample_valid,
   output logic [1:0]  color_id,
   output logic        busy,
   output logic        timeout_err
);

   localparam int PW = $clog2(SAMPLE_PERIOD + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_DONE, S_NEXT, S_PUBLISH, S_ABORT
   } state_t;

   state_t          state, next_state;
   logic [1:0]      idx;
   logic [1:0]      issue_idx;
   logic [7:0]      issue_base;
   logic [PW-1:0]   period_cnt;
   logic [WW-1:0]   wd_cnt;
   logic [15:0]     shadow [4];
   logic [15:0]     rx_word;

   // Dominant colour: a strict maximum among R/G/B, and only with enough light on clear.
   function automatic logic [1:0] classify(input logic [15:0] c, input logic [15:0] r,
                                           input logic [15:0] g, input logic [15:0] b);
      logic [1:0] id;
      id = 2'd0;
      if (c >= CLEAR_MIN) begin
         if (r > g && r > b)      id = 2'd1;
         else if (g > r && g > b) id = 2'd2;
         else if (b > r && b > g) id = 2'd3;
      end
      return id;
   endfunction

   assign m_dev_addr = DEV_ADDR;
   assign busy       = (state != S_IDLE);
   assign rx_word    = SWAP_BYTES ? {m_data[7:0], m_data[15:8]} : m_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      issue_idx  = (state == S_IDLE) ? 2'd0 : idx + 2'd1;
      issue_base = 8'h14 + {5'd0, issue_idx, 1'b0};
      case (state)
         S_IDLE:
            if (trigger || (auto_en && period_cnt == PERIOD_LAST)) next_state = S_ISSUE;
         S_ISSUE:
            if (!m_busy) next_state = S_WAIT_DONE;
         // A done arriving on the watchdog's last cycle still wins.
         S_WAIT_DONE:
            if (m_done)                  next_state = S_NEXT;
            else if (wd_cnt == WD_LAST)  next_state = S_ABORT;
         S_NEXT:
            next_state = (idx == 2'd3) ? S_PUBLISH : S_ISSUE;
         S_PUBLISH: next_state = S_IDLE;
         S_ABORT:   next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_start      <= 1'b0;
         timeout_err  <= 1'b0;
         sample_valid <= 1'b0;
         m_reg_addr   <= 8'h00;
         idx          <= 2'd0;
         wd_cnt       <= '0;
         clear_o      <= 16'd0;
         red_o        <= 16'd0;
         green_o      <= 16'd0;
         blue_o       <= 16'd0;
         color_id     <= 2'd0;
         for (int i = 0; i < 4; i++) shadow[i] <= 16'd0;
      end else begin
         m_start      <= (state == S_ISSUE) && (next_state == S_WAIT_DONE);
         timeout_err  <= (state == S_WAIT_DONE) && (next_state == S_ABORT);
         sample_valid <= (next_state == S_PUBLISH);

         if (state == S_IDLE && next_state == S_ISSUE)      idx <= 2'd0;
         else if (state == S_NEXT && next_state == S_ISSUE) idx <= idx + 2'd1;

         if (next_state == S_ISSUE && state != S_ISSUE) m_reg_addr <= CMD_PREFIX | issue_base;

         if (state == S_WAIT_DONE) wd_cnt <= wd_cnt + WW'(1);
         else                      wd_cnt <= '0;

         if (state == S_WAIT_DONE && m_done) shadow[idx] <= rx_word;

         // Publish on entry to PUBLISH so the strobe and all four channels line up.
         if (state == S_NEXT && next_state == S_PUBLISH) begin
            clear_o  <= shadow[0];
            red_o    <= shadow[1];
            green_o  <= shadow[2];
            blue_o   <= shadow[3];
            color_id <= classify(shadow[0], shadow[1], shadow[2], shadow[3]);
         end
      end
   end

   // Period timer restarts with each automatic or triggered sample and parks at its limit while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                       period_cnt <= '0;
      else if (!auto_en)                              period_cnt <= '0;
      else if (state == S_IDLE && next_state == S_ISSUE) period_cnt <= '0;
      else if (period_cnt != PERIOD_LAST)             period_cnt <= period_cnt + PW'(1);
   end

endmodule

// File: tb/tb_tcs34725_color_sampler.sv
// Scoreboard bench for tcs34725_color_sampler: a mock I2C master answers reads,
// expected register addresses and samples are queued and checked as the DUT produces them.
`timescale 1ns/1ps
module tb_tcs34725_color_sampler;

   typedef struct {
      logic [15:0] c, r, g, b;
      logic [1:0]  id;
   } sample_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger, auto_en, m_busy, m_done;
   logic [15:0] m_data;
   logic        m_start, sample_valid, busy, timeout_err;
   logic [6:0]  m_dev_addr;
   logic [7:0]  m_reg_addr;
   logic [15:0] clear_o, red_o, green_o, blue_o;
   logic [1:0]  color_id;

   int          check_count = 0;
   int          pass_count  = 0;
   int          start_count = 0;
   int          valid_count = 0;
   int          to_count    = 0;
   int          lat         = 20;
   int          hang_at     = -1;
   int          stray_req   = 0;
   int          stray_ack   = 0;
   time         start_time, valid_time, to_time;
   bit          master_alive;
   sample_t     mon_e, last_exp;
   logic [15:0] resp_q [$];
   logic [7:0]  exp_addr_q [$];
   sample_t     exp_q [$];

   tcs34725_color_sampler #(.SAMPLE_PERIOD(1000), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .auto_en(auto_en),
      .m_start(m_start), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr),
      .m_data(m_data), .m_busy(m_busy), .m_done(m_done),
      .clear_o(clear_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
      .sample_valid(sample_valid), .color_id(color_id), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #10 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got === exp) pass_count++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] swap(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   // Mock master: answers each start after lat cycles, can hang on one start or emit a stray done.
   initial begin
      m_done = 1'b0;
      m_data = 16'h0000;
      forever begin
         @(negedge clk);
         if (stray_req != stray_ack) begin
            stray_ack++;
            m_data = 16'hFFFF;
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
         end else if (m_start) begin
            start_count++;
            start_time = $time;
            if (exp_addr_q.size() > 0) checkOutput("reg_addr", m_reg_addr, exp_addr_q.pop_front());
            else                       checkOutput("unexpected_start", 1, 0);
            if (start_count != hang_at) begin
               master_alive = 1'b1;
               for (int k = 0; k < lat; k++) begin
                  @(negedge clk);
                  if (!rst) begin
                     master_alive = 1'b0;
                     break;
                  end
               end
               if (master_alive) begin
                  m_data = (resp_q.size() > 0) ? resp_q.pop_front() : 16'hDEAD;
                  m_done = 1'b1;
                  @(negedge clk);
                  m_done = 1'b0;
               end
            end
         end
      end
   end

   // Output monitor: every sample_valid must match the next queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (sample_valid) begin
            valid_count++;
            valid_time = $time;
            if (exp_q.size() == 0) checkOutput("unexpected_valid", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               checkOutput("clear_o",  clear_o,  mon_e.c);
               checkOutput("red_o",    red_o,    mon_e.r);
               checkOutput("green_o",  green_o,  mon_e.g);
               checkOutput("blue_o",   blue_o,   mon_e.b);
               checkOutput("color_id", color_id, mon_e.id);
            end
         end
         if (timeout_err) begin
            to_count++;
            to_time = $time;
         end
      end
   end

   task automatic queueSample(input logic [15:0] c, r, g, b, input logic [1:0] id);
      resp_q.push_back(swap(c));
      resp_q.push_back(swap(r));
      resp_q.push_back(swap(g));
      resp_q.push_back(swap(b));
      exp_addr_q.push_back(8'hB4);
      exp_addr_q.push_back(8'hB6);
      exp_addr_q.push_back(8'hB8);
      exp_addr_q.push_back(8'hBA);
      last_exp = '{c: c, r: r, g: g, b: b, id: id};
      exp_q.push_back(last_exp);
   endtask

   task automatic waitValid(input int target, input int limit);
      for (int k = 0; k < limit && valid_count < target; k++) @(negedge clk);
      if (valid_count < target) checkOutput("valid_wait_expired", 0, 1);
   endtask

   task automatic applyStimulus(input logic [15:0] c, r, g, b, input logic [1:0] id,
                                input int busy_hold);
      int s0, v0;
      s0 = start_count;
      v0 = valid_count;
      queueSample(c, r, g, b, id);
      if (busy_hold > 0) m_busy = 1'b1;
      @(negedge clk) trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      if (busy_hold > 0) begin
         repeat (busy_hold) @(negedge clk);
         checkOutput("start_held_by_m_busy", start_count - s0, 0);
         checkOutput("busy_while_held", busy, 1);
         m_busy = 1'b0;
      end
      waitValid(v0 + 1, 2000);
      checkOutput("start_pulses", start_count - s0, 4);
      @(negedge clk);
      checkOutput("busy_after_sample", busy, 0);
   endtask

   initial begin
      int s0, v0, t0;
      rst = 1'b0; trigger = 1'b0; auto_en = 1'b0; m_busy = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_outputs", {clear_o, red_o}, 32'h0);
      checkOutput("rst_outputs2", {green_o, blue_o}, 32'h0);
      checkOutput("rst_flags", {color_id, m_start, sample_valid, busy, timeout_err}, 0);
      checkOutput("rst_reg_addr", m_reg_addr, 8'h00);
      checkOutput("dev_addr", m_dev_addr, 7'h29);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      lat = 50;
      applyStimulus(16'h1234, 16'h1000, 16'h2000, 16'h3000, 2'd3, 0);
      lat = 20;
      applyStimulus(16'h0020, 16'h0500, 16'h0100, 16'h0100, 2'd0, 0);
      applyStimulus(16'h003F, 16'h0100, 16'h0000, 16'h0000, 2'd0, 0);
      applyStimulus(16'h0100, 16'h0200, 16'h0200, 16'h0100, 2'd0, 0);
      applyStimulus(16'h0100, 16'h0300, 16'h0200, 16'h0100, 2'd1, 0);
      applyStimulus(16'h0040, 16'h0010, 16'h0090, 16'h0010, 2'd2, 0);
      applyStimulus(16'h0800, 16'h0001, 16'h0001, 16'h0002, 2'd3, 20);

      v0 = valid_count;
      stray_req++;
      repeat (5) @(negedge clk);
      checkOutput("stray_done_valid", valid_count - v0, 0);
      checkOutput("stray_done_clear", clear_o, last_exp.c);
      checkOutput("stray_done_busy", busy, 0);

      // Watchdog: third read never completes.
      s0 = start_count; v0 = valid_count; t0 = to_count;
      resp_q.push_back(16'h1111);
      resp_q.push_back(16'h2222);
      exp_addr_q.push_back(8'hB4);
      exp_addr_q.push_back(8'hB6);
      exp_addr_q.push_back(8'hB8);
      hang_at = start_count + 3;
      @(negedge clk) trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      for (int k = 0; k < 1000 && to_count == t0; k++) @(negedge clk);
      checkOutput("timeout_seen", to_count - t0, 1);
      checkOutput("timeout_latency", int'((to_time - start_time) / 20), 100);
      checkOutput("timeout_starts", start_count - s0, 3);
      @(negedge clk);
      checkOutput("timeout_busy", busy, 0);
      checkOutput("timeout_no_valid", valid_count - v0, 0);
      checkOutput("timeout_keep_rg", {red_o, green_o}, {last_exp.r, last_exp.g});
      checkOutput("timeout_keep_cb", {clear_o, blue_o}, {last_exp.c, last_exp.b});
      checkOutput("timeout_keep_id", color_id, last_exp.id);
      hang_at = -1;

      // Auto mode with a stray trigger during the second sequence.
      lat = 10;
      s0 = start_count; v0 = valid_count;
      queueSample(16'h0200, 16'h0100, 16'h0100, 16'h0100, 2'd0);
      queueSample(16'h0200, 16'h0050, 16'h0400, 16'h0100, 2'd2);
      auto_en = 1'b1;
      waitValid(v0 + 1, 2000);
      t0 = int'(valid_time / 20);
      for (int k = 0; k < 100 && busy; k++) @(negedge clk);
      for (int k = 0; k < 1100 && !busy; k++) @(negedge clk);
      repeat (5) @(negedge clk);
      trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      waitValid(v0 + 2, 2000);
      auto_en = 1'b0;
      checkOutput("auto_period", int'(valid_time / 20) - t0, 1000);
      repeat (2500) @(negedge clk);
      checkOutput("auto_stopped_valid", valid_count - v0, 2);
      checkOutput("auto_start_pulses", start_count - s0, 8);

      // Reset during the second read's wait.
      lat = 50;
      s0 = start_count;
      resp_q.push_back(swap(16'h0AAA));
      exp_addr_q.push_back(8'hB4);
      exp_addr_q.push_back(8'hB6);
      @(negedge clk) trigger = 1'b1;
      @(negedge clk) trigger = 1'b0;
      for (int k = 0; k < 500 && start_count < s0 + 2; k++) @(negedge clk);
      checkOutput("mid_reset_reached", start_count - s0, 2);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("mid_reset_cr", {clear_o, red_o}, 32'h0);
      checkOutput("mid_reset_gb", {green_o, blue_o}, 32'h0);
      checkOutput("mid_reset_flags", {color_id, m_start, sample_valid, busy}, 0);
      resp_q.delete();
      exp_addr_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      lat = 20;
      applyStimulus(16'h0FFF, 16'hFFFF, 16'h0000, 16'hFFFE, 2'd1, 0);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
